prio_enc_rr: RTL and testbench

//  Parametrised, registered 2^N-to-N encoder; the general successor to the 8-to-3 encoder.

---
 rtl/prio_enc_rr.sv | 80 ++++++++
 tb/tb_prio_enc_rr.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_rr.sv
// Registered WIDTH-to-IDX_W priority encoder with a valid/ready handshake.
// Selects the highest set bit (MODE 0) or round-robins from a pointer (MODE 1).
module prio_enc_rr #(
    parameter int WIDTH    = 16,
    parameter int IDX_W    = $clog2(WIDTH),
    parameter int MODE     = 0,
    parameter int RR_START = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_none,
    output logic             out_multi
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] fp_idx;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win_idx;
    logic             rr_found;
    logic             any;
    logic             multi;
    logic             accept;

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        fp_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i]) fp_idx = IDX_W'(i);
        end
    end

    // WIDTH is a power of two, so the IDX_W-bit add wraps naturally.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int k = 0; k < WIDTH; k++) begin
            cand = ptr + IDX_W'(k);
            if (!rr_found && req[cand]) begin
                rr_idx   = cand;
                rr_found = 1'b1;
            end
        end
    end

    assign win_idx  = (MODE == 1) ? rr_idx : fp_idx;
    assign any      = |req;
    assign multi    = |(req & (req - WIDTH'(1)));
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            out_none   <= 1'b0;
            out_multi  <= 1'b0;
            ptr        <= IDX_W'(RR_START);
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_none   <= !any;
            out_multi  <= multi;
            out_idx    <= any ? win_idx : '0;
            out_onehot <= any ? (WIDTH'(1) << win_idx) : '0;
            if (MODE == 1 && any) ptr <= win_idx + IDX_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prio_enc_rr.sv
// Bench for prio_enc_rr: fixed-priority and round-robin instances, WIDTH 8,
// driven with shared stimulus and compared against a behavioural model.
module tb_prio_enc_rr;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] req = '0;

    logic         rdy0, v0, none0, mul0;
    logic [2:0]   idx0;
    logic [W-1:0] oh0;
    logic         rdy1, v1, none1, mul1;
    logic [2:0]   idx1;
    logic [W-1:0] oh1;

    int checks = 0;
    int errors = 0;

    logic         e_valid;
    logic [2:0]   e_idx[2];
    logic [W-1:0] e_oh[2];
    logic         e_none[2];
    logic         e_multi[2];
    int           m_ptr;

    always #5 clk = ~clk;

    prio_enc_rr #(.WIDTH(W), .MODE(0), .RR_START(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .req(req), .out_valid(v0), .out_ready(out_ready), .out_idx(idx0),
        .out_onehot(oh0), .out_none(none0), .out_multi(mul0)
    );

    prio_enc_rr #(.WIDTH(W), .MODE(1), .RR_START(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .req(req), .out_valid(v1), .out_ready(out_ready), .out_idx(idx1),
        .out_onehot(oh1), .out_none(none1), .out_multi(mul1)
    );

    function automatic int hi_bit(logic [W-1:0] r);
        for (int i = W - 1; i >= 0; i--) if (r[i]) return i;
        return 0;
    endfunction

    function automatic int rr_pick(logic [W-1:0] r, int p);
        for (int k = 0; k < W; k++) if (r[(p + k) % W]) return (p + k) % W;
        return 0;
    endfunction

    task automatic model_reset();
        e_valid = 1'b0;
        m_ptr   = 0;
        for (int m = 0; m < 2; m++) begin
            e_idx[m]   = '0;
            e_oh[m]    = '0;
            e_none[m]  = 1'b0;
            e_multi[m] = 1'b0;
        end
    endtask

    // Update the model from the inputs in force at the coming edge, then
    // advance to just after that edge.
    task automatic step();
        bit acc;
        int w;
        acc = in_valid && (!e_valid || out_ready);
        if (acc) begin
            for (int m = 0; m < 2; m++) begin
                w          = (m == 0) ? hi_bit(req) : rr_pick(req, m_ptr);
                e_none[m]  = (req == 0);
                e_multi[m] = ($countones(req) > 1);
                e_idx[m]   = e_none[m] ? 3'd0 : w[2:0];
                e_oh[m]    = e_none[m] ? '0 : (W'(1) << w);
            end
            if (req != 0) m_ptr = (rr_pick(req, m_ptr) + 1) % W;
            e_valid = 1'b1;
        end else if (out_ready) begin
            e_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({v0, idx0, oh0, none0, mul0, v1, idx1, oh1, none1, mul1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h %h required 0",
                     {v0, idx0, oh0, none0, mul0}, {v1, idx1, oh1, none1, mul1});
        end
        checks++;
        if ({rdy0, rdy1} !== 2'b11) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 11", {rdy0, rdy1});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fixed_prio();
        in_valid = 1'b1;
        out_ready = 1'b1;
        req = 8'b0010_1001;
        step();
        checks++;
        if ({v0, idx0, oh0, none0, mul0} !== {1'b1, 3'd5, 8'h20, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL fixed_prio_29: got %h required %h",
                     {v0, idx0, oh0, none0, mul0}, {1'b1, 3'd5, 8'h20, 1'b0, 1'b1});
        end
        req = 8'h00;
        step();
        checks++;
        if ({v0, idx0, oh0, none0, mul0} !== {1'b1, 3'd0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fixed_prio_zero: got %h required %h",
                     {v0, idx0, oh0, none0, mul0}, {1'b1, 3'd0, 8'h00, 1'b1, 1'b0});
        end
        checks++;
        if ({v1, idx1, oh1, none1, mul1} !== {1'b1, 3'd0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rr_zero: got %h required %h",
                     {v1, idx1, oh1, none1, mul1}, {1'b1, 3'd0, 8'h00, 1'b1, 1'b0});
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1;
        out_ready = 1'b1;
        req = 8'h12;
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req = W'($urandom);
            #1;
            checks++;
            if ({rdy0, rdy1} !== 2'b00) begin
                errors++;
                $display("FAIL stall_in_ready c%0d: got %b required 00", c, {rdy0, rdy1});
            end
            step();
            checks++;
            if ({v0, idx0, oh0, none0, mul0} !== {1'b1, 3'd4, 8'h10, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold c%0d: got %h required %h", c,
                         {v0, idx0, oh0, none0, mul0}, {1'b1, 3'd4, 8'h10, 1'b0, 1'b1});
            end
            checks++;
            if ({v1, idx1, oh1, none1, mul1} !== {e_valid, e_idx[1], e_oh[1], e_none[1], e_multi[1]}) begin
                errors++;
                $display("FAIL stall_hold_rr c%0d: got %h required %h", c,
                         {v1, idx1, oh1, none1, mul1},
                         {e_valid, e_idx[1], e_oh[1], e_none[1], e_multi[1]});
            end
        end
        out_ready = 1'b1;
        req = 8'h40;
        #1;
        checks++;
        if (rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL drain_in_ready: got %b required 1", rdy0);
        end
        step();
        checks++;
        if ({v0, idx0, oh0} !== {1'b1, 3'd6, 8'h40}) begin
            errors++;
            $display("FAIL no_bubble: got %h required %h", {v0, idx0, oh0}, {1'b1, 3'd6, 8'h40});
        end
        in_valid = 1'b0;
        step();
        checks++;
        if ({v0, idx0, oh0} !== {1'b0, 3'd6, 8'h40}) begin
            errors++;
            $display("FAIL drain_hold: got %h required %h", {v0, idx0, oh0}, {1'b0, 3'd6, 8'h40});
        end
    endtask

    task automatic test_rr_wrap();
        do_reset();
        in_valid = 1'b1;
        out_ready = 1'b1;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            checks++;
            if ({v1, idx1, oh1} !== {1'b1, 3'(k % 8), 8'(1 << (k % 8))}) begin
                errors++;
                $display("FAIL rr_wrap k%0d: got idx %0d oh %h required idx %0d", k, idx1, oh1, k % 8);
            end
        end
    endtask

    task automatic test_rr_ptr();
        do_reset();
        in_valid = 1'b1;
        out_ready = 1'b1;
        req = 8'h01;
        step();
        req = 8'b1000_0001;
        step();
        checks++;
        if ({idx1, mul1} !== {3'd7, 1'b1}) begin
            errors++;
            $display("FAIL rr_ptr_hi: got idx %0d multi %b required 7 1", idx1, mul1);
        end
        step();
        checks++;
        if (idx1 !== 3'd0) begin
            errors++;
            $display("FAIL rr_ptr_wrap: got idx %0d required 0", idx1);
        end
    endtask

    task automatic test_reset_mid_stall();
        in_valid = 1'b1;
        out_ready = 1'b1;
        req = 8'h0C;
        step();
        out_ready = 1'b0;
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({v0, idx0, oh0, none0, mul0, v1, idx1, oh1, none1, mul1} !== '0) begin
            errors++;
            $display("FAIL reset_mid_stall: got %h %h required 0",
                     {v0, idx0, oh0, none0, mul0}, {v1, idx1, oh1, none1, mul1});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if ({v0, v1} !== 2'b00) begin
            errors++;
            $display("FAIL no_replay: got %b required 00", {v0, v1});
        end
        in_valid = 1'b1;
        req = 8'hFF;
        step();
        checks++;
        if ({v1, idx1} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL ptr_after_reset: got idx %0d required 0", idx1);
        end
    endtask

    task automatic test_random();
        int sel;
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 3);
            if (sel == 0) req = '0;
            else if (sel == 1) req = W'(1) << $urandom_range(0, W - 1);
            else req = W'($urandom);
            #1;
            checks++;
            if ({rdy0, rdy1} !== {2{!e_valid || out_ready}}) begin
                errors++;
                $display("FAIL rand_in_ready n%0d: got %b required %b", n,
                         {rdy0, rdy1}, {2{!e_valid || out_ready}});
            end
            step();
            checks++;
            if ({v0, idx0, oh0, none0, mul0} !== {e_valid, e_idx[0], e_oh[0], e_none[0], e_multi[0]}) begin
                errors++;
                $display("FAIL rand_fixed n%0d: got %h required %h", n,
                         {v0, idx0, oh0, none0, mul0},
                         {e_valid, e_idx[0], e_oh[0], e_none[0], e_multi[0]});
            end
            checks++;
            if ({v1, idx1, oh1, none1, mul1} !== {e_valid, e_idx[1], e_oh[1], e_none[1], e_multi[1]}) begin
                errors++;
                $display("FAIL rand_rr n%0d: got %h required %h", n,
                         {v1, idx1, oh1, none1, mul1},
                         {e_valid, e_idx[1], e_oh[1], e_none[1], e_multi[1]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_prio();
        test_backpressure();
        test_rr_wrap();
        test_rr_ptr();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
